// File: rtl/register_file_pkg.sv
// Shared sizing constants and types for the 32 x 32 RISC-V integer register file.
package register_file_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/register_file_if.sv
// Decode/writeback-facing bus of the register file: one write port, two read ports.
interface register_file_if;
  import register_file_pkg::*;

  logic      RW;
  reg_addr_t DA;
  reg_addr_t AA;
  reg_addr_t BA;
  reg_data_t D;
  reg_data_t A;
  reg_data_t B;

  modport master (output RW, DA, AA, BA, D, input A, B);
  modport slave  (input RW, DA, AA, BA, D, output A, B);
endinterface

// File: rtl/register_file_read_port.sv
// Combinational read mux; address 0 is forced to zero since x0 has no storage.
module regfile_read_port
  import register_file_pkg::*;
(
  input  reg_addr_t addr_i,
  input  reg_data_t regs_i [1:NUM_REGS-1],
  output reg_data_t data_o
);

  always_comb begin
    data_o = '0;
    if (addr_i != ZERO_REG) data_o = regs_i[addr_i];
  end

endmodule

// File: rtl/register_file.sv
// 32 x 32 register file: synchronous write port D, asynchronous read ports A/B, x0 hardwired to 0.
module register_file
  import register_file_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  register_file_if.slave bus
);

  // Entries 1..31 only; x0 is produced by the read ports, so writes to it have nowhere to land.
  reg_data_t regs_q [1:NUM_REGS-1];
  reg_data_t regs_d [1:NUM_REGS-1];

  always_comb begin
    regs_d = regs_q;
    if (bus.RW && (bus.DA != ZERO_REG)) regs_d[bus.DA] = bus.D;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // No write-to-read bypass: forwarding is left to the pipeline.
  regfile_read_port u_port_a (
    .addr_i (bus.AA),
    .regs_i (regs_q),
    .data_o (bus.A)
  );

  regfile_read_port u_port_b (
    .addr_i (bus.BA),
    .regs_i (regs_q),
    .data_o (bus.B)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, writes, x0, write-disable, read-during-write, dual read.
module tb_register_file;
  import register_file_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  register_file_if bus ();

  register_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input reg_data_t obs, input reg_data_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reg_data_t vals [1:5];
    reg_data_t prev;
    vals[1] = 32'd15; vals[2] = 32'd25; vals[3] = 32'd35; vals[4] = 32'd55; vals[5] = 32'd45;
    checks = 0;
    errors = 0;

    // Reset held low with a pending write: nothing may land, every read is 0.
    rst_n  = 1'b0;
    bus.RW = 1'b1;
    bus.DA = 5'd5;
    bus.D  = 32'hFFFF_FFFF;
    bus.AA = '0;
    bus.BA = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      bus.AA = reg_addr_t'(i);
      bus.BA = reg_addr_t'(NUM_REGS - 1 - i);
      #1;
      check($sformatf("reset_A[%0d]", i), bus.A, '0);
      check($sformatf("reset_B[%0d]", NUM_REGS - 1 - i), bus.B, '0);
    end
    @(negedge clk);
    bus.RW = 1'b0;
    rst_n  = 1'b1;
    bus.AA = 5'd5;
    #1;
    check("reset_overrides_write", bus.A, '0);

    // Sequential writes r1..r5; A looks at the previous register, B at the one just written.
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      bus.RW = 1'b1;
      bus.DA = reg_addr_t'(i);
      bus.D  = vals[i];
      bus.AA = reg_addr_t'(i - 1);
      bus.BA = reg_addr_t'(i);
      @(posedge clk);
      #1;
      prev = (i == 1) ? '0 : vals[i-1];
      check($sformatf("seq_B_r%0d", i), bus.B, vals[i]);
      check($sformatf("seq_A_r%0d", i - 1), bus.A, prev);
    end

    // x0 write is discarded.
    @(negedge clk);
    bus.RW = 1'b1;
    bus.DA = 5'd0;
    bus.D  = 32'hDEAD_BEEF;
    bus.AA = 5'd0;
    bus.BA = 5'd0;
    @(posedge clk);
    #1;
    check("x0_A", bus.A, '0);
    check("x0_B", bus.B, '0);

    // RW low leaves r3 alone, even with X on D.
    @(negedge clk);
    bus.RW = 1'b0;
    bus.DA = 5'd3;
    bus.D  = 32'd99;
    bus.AA = 5'd3;
    @(posedge clk);
    #1;
    check("wr_disable_r3", bus.A, 32'd35);
    @(negedge clk);
    bus.D = 'x;
    @(posedge clk);
    #1;
    check("x_on_D_r3", bus.A, 32'd35);

    // Read-during-write on r7: old value before the edge, new value after.
    @(negedge clk);
    bus.RW = 1'b1;
    bus.DA = 5'd7;
    bus.D  = 32'd123;
    bus.BA = 5'd7;
    #1;
    check("rdw_before_edge", bus.B, '0);
    @(posedge clk);
    #1;
    check("rdw_after_edge", bus.B, 32'd123);

    // Both ports on the same register.
    @(negedge clk);
    bus.RW = 1'b0;
    bus.AA = 5'd4;
    bus.BA = 5'd4;
    #1;
    check("dual_A_r4", bus.A, 32'd55);
    check("dual_B_r4", bus.B, 32'd55);

    // Fill r1..r31 with index*3, then read all with A ascending and B descending.
    for (int i = 1; i < NUM_REGS; i++) begin
      @(negedge clk);
      bus.RW = 1'b1;
      bus.DA = reg_addr_t'(i);
      bus.D  = reg_data_t'(i * 3);
    end
    @(negedge clk);
    bus.RW = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      bus.AA = reg_addr_t'(i);
      bus.BA = reg_addr_t'(NUM_REGS - 1 - i);
      #1;
      check($sformatf("fill_A[%0d]", i), bus.A, reg_data_t'(i * 3));
      check($sformatf("fill_B[%0d]", NUM_REGS - 1 - i), bus.B, reg_data_t'((NUM_REGS - 1 - i) * 3));
    end

    // Mid-run asynchronous reset clears r1 without a clock edge.
    @(negedge clk);
    bus.RW = 1'b1;
    bus.DA = 5'd1;
    bus.D  = 32'd15;
    bus.AA = 5'd1;
    @(posedge clk);
    #1;
    bus.RW = 1'b0;
    check("pre_async_r1", bus.A, 32'd15);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_r1", bus.A, '0);
    bus.AA = 5'd31;
    #1;
    check("async_reset_r31", bus.A, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("after_reset_r31", bus.A, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
